// File: rtl/uart_pkg.sv
// Shared UART definitions for the serial debug unit: FSM state encoding and
// default frame parameters. Imported by both the TX and RX blocks.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;  // clk cycles per bit (16*9600 Hz clk -> 9600 baud)
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts OVERSAMPLE clk cycles per bit and flags the last
// cycle of each bit with a one-cycle o_bit_done pulse. Held at zero by i_clr.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_done
);

    localparam int                TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] r_tick;

    // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tick <= '0;
        end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    assign o_bit_done = (r_tick == TICK_LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter of the serial debug unit: one-entry holding register behind a
// vld/rdy handshake, feeding an 8N1 LSB-first serialiser with a registered txd.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] d_tx,
    input  logic                 vld_tx,
    output logic                 rdy_tx,
    output logic                 txd,
    output logic                 busy
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    uart_state_t          r_state;
    logic                 r_txd;
    logic                 r_busy;

    logic w_bit_done;
    logic w_accept;
    logic w_last_data;
    logic w_last_stop;
    logic w_load;
    logic w_tmr_clr;

    assign w_accept    = vld_tx & ~r_hold_full;
    assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

    // Hold -> shift transfer: from IDLE at once, or at the end of STOP for a gapless next frame.
    assign w_load = r_hold_full &
                    ((r_state == IDLE) | ((r_state == STOP) & w_bit_done & w_last_stop));

    // NOTE: default assigned first so no path through the case leaves w_tmr_clr unassigned (no latch).
    always_comb begin
        w_tmr_clr = 1'b0;
        case (r_state)
            IDLE:    w_tmr_clr = 1'b1;
            START:   w_tmr_clr = w_bit_done;
            DATA:    w_tmr_clr = w_bit_done & w_last_data;
            STOP:    w_tmr_clr = w_bit_done & w_last_stop;
            default: w_tmr_clr = 1'b1;
        endcase
    end

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_tmr_clr),
        .o_bit_done (w_bit_done)
    );

    // NOTE: r_hold is pure data qualified by r_hold_full, so only the flag needs a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= d_tx;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        r_shift <= r_hold;
                        r_state <= START;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                        r_txd     <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (w_last_data) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                            r_txd     <= 1'b1;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        if (!w_last_stop) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (r_hold_full) begin
                            r_shift <= r_hold;
                            r_state <= START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rdy_tx = ~r_hold_full;
    assign txd    = r_txd;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: frame-timeline model compared every cycle,
// a line receiver decoding txd, and directed handshake/reset scenarios.
module tb_uart_tx_unit;

    localparam int OS        = 16;
    localparam int FRAME_LEN = 10 * OS;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_tx;
    logic       vld_tx;
    logic       rdy_tx;
    logic       txd;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_unit dut (
        .clk    (clk),
        .rst    (rst),
        .d_tx   (d_tx),
        .vld_tx (vld_tx),
        .rdy_tx (rdy_tx),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-timeline model: m_pos is the cycle index inside the current frame (-1 = line idle).
    int         m_pos       = -1;
    logic [7:0] m_byte      = '0;
    logic [7:0] m_hold      = '0;
    bit         m_hold_full = 0;
    bit         m_valid     = 0;

    always @(posedge clk) begin
        bit accept;
        bit start_new;
        if (rst) begin
            m_pos       = -1;
            m_hold_full = 0;
            m_valid     = 1;
        end else begin
            accept    = vld_tx && !m_hold_full;
            start_new = 0;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME_LEN) begin
                    m_pos     = -1;
                    start_new = m_hold_full;
                end
            end else begin
                start_new = m_hold_full;
            end
            if (start_new) begin
                m_byte      = m_hold;
                m_pos       = 0;
                m_hold_full = 0;
            end
            if (accept) begin
                m_hold      = d_tx;
                m_hold_full = 1;
            end
        end
    end

    function automatic logic exp_txd();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / OS;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_txd", txd, exp_txd());
            check("model_busy", busy, (m_pos >= 0));
            check("model_rdy", rdy_tx, !m_hold_full);
        end
    end

    // Run-length monitors for busy high and rdy_tx low.
    int busy_run = 0, busy_last = 0, rdy_run = 0, rdy_last = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin busy_last = busy_run; busy_run = 0; end
        if (rdy_tx === 1'b0) rdy_run++;
        else if (rdy_run > 0) begin rdy_last = rdy_run; rdy_run = 0; end
    end

    // Line receiver standing in for RX: samples each bit mid-period.
    int         rx_t = -1;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            rx_t = -1;
        end else begin
            if (rx_t < 0) begin
                if (txd == 1'b0) rx_t = 0;
            end else begin
                rx_t++;
            end
            if (rx_t == 8) check("rx_start", txd, 1'b0);
            if (rx_t >= 24 && rx_t <= 136 && (rx_t % OS) == 8) rx_sh[rx_t / OS - 1] = txd;
            if (rx_t == 152) begin
                check("rx_stop", txd, 1'b1);
                rx_q.push_back(rx_sh);
                rx_t = -1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic offer(input logic [7:0] b, output int waited);
        d_tx   = b;
        vld_tx = 1'b1;
        waited = 0;
        while (rdy_tx !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("offer_rdy", rdy_tx, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && rdy_tx === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", busy, 1'b0);
        check("idle_rdy", rdy_tx, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check(name, rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int         w;
        int         busy_seen;
        logic [9:0] got;
        logic [9:0] exp_bits;

        // 1: reset with vld_tx high
        rst    = 1'b1;
        vld_tx = 1'b1;
        d_tx   = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_txd", txd, 1'b1);
            check("rst_rdy", rdy_tx, 1'b1);
            check("rst_busy", busy, 1'b0);
        end
        rst    = 1'b0;
        vld_tx = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("rst_no_frame", busy_seen, 0);

        // 2: single byte 0xA5, one-cycle vld pulse
        rx_q.delete();
        offer(8'hA5, w);
        vld_tx = 1'b0;
        got = '0;
        for (int c = 0; c <= 9 * OS + 9; c++) begin
            if (c >= 9 && ((c - 9) % OS) == 0) got[(c - 9) / OS] = txd;
            @(negedge clk);
        end
        exp_bits = 10'h34A;
        check("a5_bits", got, exp_bits);
        wait_idle();
        check("a5_busy_len", busy_last, 160);
        check("a5_rdy_low", rdy_last, 1);
        exp_q.delete(); exp_q.push_back(8'hA5);
        check_rx("a5_rx");

        // 3: back-to-back 0x55, 0x0F with vld held
        rx_q.delete();
        offer(8'h55, w);
        offer(8'h0F, w);
        check("bb_wait2", w, 1);
        vld_tx = 1'b0;
        wait_idle();
        check("bb_busy_len", busy_last, 320);
        exp_q.delete(); exp_q.push_back(8'h55); exp_q.push_back(8'h0F);
        check_rx("bb_rx");

        // 4: third byte offered while hold is full
        rx_q.delete();
        offer(8'h55, w);
        offer(8'h0F, w);
        offer(8'h81, w);
        check("three_wait3", w, 159);
        vld_tx = 1'b0;
        wait_idle();
        check("three_busy_len", busy_last, 480);
        exp_q.delete(); exp_q.push_back(8'h55); exp_q.push_back(8'h0F); exp_q.push_back(8'h81);
        check_rx("three_rx");

        // 5: reset during data bit 4 of 0xC3 with 0x3C buffered
        rx_q.delete();
        offer(8'hC3, w);
        offer(8'h3C, w);
        vld_tx = 1'b0;
        repeat (85) @(negedge clk);
        check("abort_bit4", txd, 1'b0);
        check("abort_hold_full", rdy_tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_txd", txd, 1'b1);
        check("abort_rdy", rdy_tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        busy_seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("abort_no_frame", busy_seen, 0);
        exp_q.delete();
        check_rx("abort_rx");

        // 6: loopback stream into the line receiver
        rx_q.delete();
        offer(8'h00, w);
        offer(8'hFF, w);
        offer(8'h3C, w);
        offer(8'hA5, w);
        vld_tx = 1'b0;
        wait_idle();
        check("loop_busy_len", busy_last, 640);
        exp_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C); exp_q.push_back(8'hA5);
        check_rx("loop_rx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
